// File: rtl/me_mem_port_pkg.sv
// Shared types and constants for the memory-stage port: FSM states, access size codes,
// beat width and reset level.
package me_mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT1 = 2'b01,
    ST_BEAT2 = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int   BEAT_BYTES = 8;
  localparam logic RST_ACTIVE = 1'b0;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/me_mem_port_lane_align.sv
// Byte-lane steering for one access: byte-enable mask, split detection, per-beat write
// data and the shifted read terms that are merged into a right-justified result.
module me_lane_align
  import me_mem_port_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        off,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [15:0]       mask,
  output logic              split,
  output logic [DATA_W-1:0] wdata_b1,
  output logic [DATA_W-1:0] wdata_b2,
  output logic [DATA_W-1:0] rdata_b1,
  output logic [DATA_W-1:0] rdata_b2,
  output logic [DATA_W-1:0] rd_keep
);

  logic [3:0] nb;
  logic [4:0] span;
  logic [6:0] sh_lo;
  logic [6:0] sh_hi;

  function automatic logic [63:0] keep_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      SZ_D:    return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'h0;
    endcase
  endfunction

  always_comb begin
    nb    = size_bytes(size);
    span  = {2'b00, off} + {1'b0, nb};
    split = (span > 5'(BEAT_BYTES));
    mask  = ((16'd1 << nb) - 16'd1) << off;
    sh_lo = {1'b0, off, 3'b000};
    // Offset 0 gives a 64-bit shift, which clears the second-beat terms as intended.
    sh_hi = 7'(BEAT_BYTES * 8) - sh_lo;
    wdata_b1 = wdata << sh_lo;
    wdata_b2 = wdata >> sh_hi;
    rdata_b1 = rdata >> sh_lo;
    rdata_b2 = rdata << sh_hi;
    rd_keep  = keep_mask(size);
  end

endmodule

// File: rtl/me_mem_port.sv
// Memory-stage responder: issues one request as one or two 8-byte-aligned cache beats and
// retires it with a right-justified read result. ME_MEM_PORT_PERF_EN adds perf counters.
module me_mem_port
  import me_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_v,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [7:0]        dc_be,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_ready,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              rsp_v,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy_out
`ifdef ME_MEM_PORT_PERF_EN
  ,
  output logic [15:0]       split_cnt,
  output logic [15:0]       wait_cnt
`endif
);

  state_t state, nxt;

  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        size_p1;
  logic              we_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] acc_p1;
  logic              flushed_p1;

  logic [15:0]       mask;
  logic              split;
  logic [DATA_W-1:0] wdata_b1, wdata_b2, rdata_b1, rdata_b2, rd_keep;
  logic [ADDR_W-4:0] line_nxt;
  logic              accept, beat_done, last_beat, kill;

  me_lane_align #(.DATA_W(DATA_W)) u_align (
    .off      (addr_p1[2:0]),
    .size     (size_p1),
    .wdata    (wdata_p1),
    .rdata    (dc_rdata),
    .mask     (mask),
    .split    (split),
    .wdata_b1 (wdata_b1),
    .wdata_b2 (wdata_b2),
    .rdata_b1 (rdata_b1),
    .rdata_b2 (rdata_b2),
    .rd_keep  (rd_keep)
  );

  assign accept    = req_v & req_rdy;
  assign beat_done = dc_req & dc_ready;
  assign last_beat = beat_done & ((state == ST_BEAT2) | ((state == ST_BEAT1) & ~split));
  assign kill      = flush | flushed_p1;
  assign line_nxt  = addr_p1[ADDR_W-1:3] + (ADDR_W-3)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) state <= ST_IDLE;
    else                     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (accept) nxt = ST_BEAT1;
      ST_BEAT1: if (beat_done) nxt = split ? ST_BEAT2 : ST_RESP;
      ST_BEAT2: if (beat_done) nxt = ST_RESP;
      ST_RESP:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy  = (state == ST_IDLE);
    busy_out = ~req_rdy;
    dc_req   = 1'b0;
    dc_we    = 1'b0;
    dc_addr  = '0;
    dc_be    = '0;
    dc_wdata = '0;
    rsp_v    = 1'b0;
    case (state)
      ST_BEAT1: begin
        dc_req   = 1'b1;
        dc_we    = we_p1;
        dc_addr  = {addr_p1[ADDR_W-1:3], 3'b000};
        dc_be    = mask[7:0];
        dc_wdata = wdata_b1;
      end
      ST_BEAT2: begin
        dc_req   = 1'b1;
        dc_we    = we_p1;
        dc_addr  = {line_nxt, 3'b000};
        dc_be    = mask[15:8];
        dc_wdata = wdata_b2;
      end
      ST_RESP: rsp_v = ~kill;
      default: ;
    endcase
  end

  // p1: request fields captured at accept, held for the life of the access
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= req_addr;
      size_p1  <= req_size;
      we_p1    <= req_we;
      wdata_p1 <= req_wdata;
    end
    if ((state == ST_BEAT1) && beat_done) acc_p1 <= rdata_b1;
  end

  // A flush seen during the beats only cancels the retire; the beats still complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) flushed_p1 <= 1'b0;
    else if (accept) flushed_p1 <= 1'b0;
    else if (flush && ((state == ST_BEAT1) || (state == ST_BEAT2))) flushed_p1 <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) rsp_rdata <= '0;
    else if (last_beat && !we_p1 && !kill)
      rsp_rdata <= ((state == ST_BEAT2) ? (acc_p1 | rdata_b2) : rdata_b1) & rd_keep;
  end

`ifdef ME_MEM_PORT_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) begin
      split_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if ((state == ST_BEAT2) && beat_done) split_cnt <= sat_inc(split_cnt);
      if (dc_req && !dc_ready) wait_cnt <= sat_inc(wait_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_me_mem_port.sv
// Randomized bench for me_mem_port against a byte-level reference model of the access.
module tb_me_mem_port;

  logic        clk, rst_n;
  logic        req_v, req_rdy, req_we, flush;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        dc_req, dc_we, dc_ready;
  logic [31:0] dc_addr;
  logic [7:0]  dc_be;
  logic [63:0] dc_wdata, dc_rdata;
  logic        rsp_v, busy_out;
  logic [63:0] rsp_rdata;
`ifdef ME_MEM_PORT_PERF_EN
  logic [15:0] split_cnt, wait_cnt;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_rsp = '0;

  me_mem_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_v     (req_v),
    .req_rdy   (req_rdy),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .flush     (flush),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_be     (dc_be),
    .dc_wdata  (dc_wdata),
    .dc_ready  (dc_ready),
    .dc_rdata  (dc_rdata),
    .rsp_v     (rsp_v),
    .rsp_rdata (rsp_rdata),
    .busy_out  (busy_out)
`ifdef ME_MEM_PORT_PERF_EN
    ,
    .split_cnt (split_cnt),
    .wait_cnt  (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode < 0: random ready; mode >= 0: ready low for the first 'mode' cycles of each beat.
  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic we,
                        input logic [63:0] wd, input int mode, input bit fl,
                        input bit fixrd, input logic [63:0] rdfix);
    int          nb, off, nbeats, bi, cyc, wc, rsp_cnt, rsp_cyc, last_done, lane, k;
    logic [31:0] ba, la, h_addr;
    logic [7:0]  ebe, h_be;
    logic [63:0] ewd, lmask, rd, res, h_wd;
    logic [63:0] capt [2];
    bit          done, holding;

    nb = 1 << sz;
    off = int'(a[2:0]);
    nbeats = (off + nb > 8) ? 2 : 1;
    bi = 0; wc = 0; rsp_cnt = 0; rsp_cyc = -1; last_done = 0;
    done = 0; holding = 0; res = '0;
    capt[0] = '0; capt[1] = '0;
    h_addr = '0; h_be = '0; h_wd = '0;

    @(negedge clk);
    req_v = 1'b1; req_addr = a; req_size = sz; req_we = we; req_wdata = wd; dc_ready = 1'b0;
    @(negedge clk);
    req_v = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
    cyc = 1;
    #1;
    chk("dc_req_t1", dc_req, 1'b1);
    chk("busy_t1", busy_out, 1'b1);
    while (!done) begin
      flush    = (fl && cyc == 1);
      dc_ready = (mode < 0) ? 1'($urandom_range(0, 1)) : (wc >= mode);
      rd       = fixrd ? rdfix : {$urandom, $urandom};
      dc_rdata = rd;
      #1;
      if (rsp_v) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (!we) begin
          for (int i = 0; i < nb; i++) begin
            la = a + 32'(i);
            k = (la[31:3] != a[31:3]) ? 1 : 0;
            lane = int'(la[2:0]);
            res[8*i +: 8] = capt[k][8*lane +: 8];
          end
          chk("rsp_data", rsp_rdata, res);
        end
      end
      if (dc_req) begin
        if (holding) begin
          chk("hold_addr", dc_addr, h_addr);
          chk("hold_be", dc_be, h_be);
          chk("hold_wdata", dc_wdata, h_wd);
        end else begin
          h_addr = dc_addr; h_be = dc_be; h_wd = dc_wdata; holding = 1;
        end
        if (dc_ready) begin
          if (bi < nbeats) begin
            ba = {a[31:3], 3'b000} + 32'(8 * bi);
            ebe = '0; ewd = '0; lmask = '0;
            for (int i = 0; i < nb; i++) begin
              la = a + 32'(i);
              if ({la[31:3], 3'b000} == ba) begin
                lane = int'(la[2:0]);
                ebe[lane] = 1'b1;
                ewd[8*lane +: 8] = wd[8*i +: 8];
                lmask[8*lane +: 8] = 8'hFF;
              end
            end
            chk("beat_addr", dc_addr, ba);
            chk("beat_be", dc_be, ebe);
            chk("beat_we", dc_we, we);
            if (we) chk("beat_wdata", dc_wdata & lmask, ewd);
            capt[bi] = rd;
          end else begin
            chk("extra_beat", 1'b1, 1'b0);
          end
          bi++; wc = 0; holding = 0; last_done = cyc;
        end else begin
          wc++;
        end
      end
      if (req_rdy && cyc > 1) done = 1;
      else if (cyc > 60) begin
        chk("timeout", 1'b0, 1'b1);
        done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    flush = 1'b0; dc_ready = 1'b0;

    if (!we && !fl) exp_rsp = res;
    chk("beats", 64'(bi), 64'(nbeats));
    chk("rsp_count", 64'(rsp_cnt), fl ? 64'd0 : 64'd1);
    if (!fl)
      chk("rsp_cyc", 64'(rsp_cyc), (mode >= 0) ? 64'(1 + nbeats * (mode + 1)) : 64'(last_done + 1));
    #1;
    chk("rdy_back", req_rdy, 1'b1);
    chk("rsp_hold", rsp_rdata, exp_rsp);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; flush = 1'b0; dc_ready = 1'b0; dc_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", req_rdy, 1'b1);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_dc_req", dc_req, 1'b0);
    chk("rst_dc_addr", dc_addr, 32'h0);
    chk("rst_dc_be", dc_be, 8'h0);
    chk("rst_rsp_v", rsp_v, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    rst_n = 1'b1;

    do_req(32'h0000_1000, 2'b10, 1'b0, 64'h0, 0, 1'b0, 1'b1, 64'h1122_3344_5566_7788);
    chk("tp_aligned_read", rsp_rdata, 64'h0000_0000_5566_7788);
    do_req(32'h0000_2006, 2'b10, 1'b1, 64'hAABB_CCDD, 0, 1'b0, 1'b0, 64'h0);
    do_req(32'h0000_300F, 2'b01, 1'b0, 64'h0, 2, 1'b0, 1'b0, 64'h0);
    do_req(32'hFFFF_FFFC, 2'b11, 1'b1, 64'h0102_0304_0506_0708, 0, 1'b0, 1'b0, 64'h0);
    do_req(32'hFFFF_FFFC, 2'b11, 1'b0, 64'h0, 1, 1'b0, 1'b0, 64'h0);
    do_req(32'h0000_4000, 2'b11, 1'b0, 64'h0, 0, 1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    chk("tp_full_read", rsp_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    do_req(32'h0000_5005, 2'b10, 1'b1, 64'h1234_5678, 0, 1'b1, 1'b0, 64'h0);
    do_req(32'h0000_5003, 2'b11, 1'b0, 64'h0, -1, 1'b1, 1'b0, 64'h0);

    for (int n = 0; n < 40; n++) begin
      a  = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      sz = 2'($urandom_range(0, 3));
      do_req(a, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom},
             $urandom_range(0, 3) - 1, ($urandom_range(0, 5) == 0), 1'b0, 64'h0);
    end

    // Reset while the second beat of a split read is waiting on the cache.
    @(negedge clk);
    req_v = 1'b1; req_addr = 32'h0000_300F; req_size = 2'b01; req_we = 1'b0; dc_ready = 1'b0;
    @(negedge clk);
    req_v = 1'b0; dc_ready = 1'b1;
    @(negedge clk);
    dc_ready = 1'b0;
    #1;
    chk("b2_dc_req", dc_req, 1'b1);
    chk("b2_dc_addr", dc_addr, 32'h0000_3010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_dc_req", dc_req, 1'b0);
    chk("rst_async_rdy", req_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", req_rdy, 1'b1);
    chk("post_rst_rsp_rdata", rsp_rdata, 64'h0);
`ifdef ME_MEM_PORT_PERF_EN
    chk("post_rst_split_cnt", split_cnt, 16'h0);
    chk("post_rst_wait_cnt", wait_cnt, 16'h0);
`endif
    exp_rsp = '0;
    do_req(32'h0000_6006, 2'b10, 1'b0, 64'h0, 0, 1'b0, 1'b0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
